// File: rtl/ram_bist_pkg.sv
// Shared types for the March C- BIST engine: FSM state encoding and the
// per-element operation table that drives the RAM port generation.
package ram_bist_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_M0    = 4'd1,
    ST_M1    = 4'd2,
    ST_M2    = 4'd3,
    ST_M3    = 4'd4,
    ST_M4    = 4'd5,
    ST_M5    = 4'd6,
    ST_DRAIN = 4'd7,
    ST_DONE  = 4'd8
  } state_t;

  // read_val / write_val select D0 (0) or D1 (1); the background inverts both.
  typedef struct packed {
    logic dir_down;
    logic do_read;
    logic read_val;
    logic do_write;
    logic write_val;
  } march_elem_t;

  function automatic march_elem_t elem_of(input state_t s);
    march_elem_t e;
    e = '0;
    case (s)
      ST_M0:   e = '{dir_down: 1'b0, do_read: 1'b0, read_val: 1'b0, do_write: 1'b1, write_val: 1'b0};
      ST_M1:   e = '{dir_down: 1'b0, do_read: 1'b1, read_val: 1'b0, do_write: 1'b1, write_val: 1'b1};
      ST_M2:   e = '{dir_down: 1'b0, do_read: 1'b1, read_val: 1'b1, do_write: 1'b1, write_val: 1'b0};
      ST_M3:   e = '{dir_down: 1'b1, do_read: 1'b1, read_val: 1'b0, do_write: 1'b1, write_val: 1'b1};
      ST_M4:   e = '{dir_down: 1'b1, do_read: 1'b1, read_val: 1'b1, do_write: 1'b1, write_val: 1'b0};
      ST_M5:   e = '{dir_down: 1'b1, do_read: 1'b1, read_val: 1'b0, do_write: 1'b0, write_val: 1'b0};
      default: e = '0;
    endcase
    return e;
  endfunction

  function automatic state_t next_elem(input state_t s);
    state_t n;
    case (s)
      ST_M0:   n = ST_M1;
      ST_M1:   n = ST_M2;
      ST_M2:   n = ST_M3;
      ST_M3:   n = ST_M4;
      ST_M4:   n = ST_M5;
      default: n = ST_DRAIN;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/ram_bist_cmp.sv
// Read-compare stage: registers each issued read, compares it against the RAM's
// registered data one cycle later, and keeps first-failure details plus a saturating count.
module bist_cmp #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  issue,
  input  logic [ADDR_WIDTH-1:0] issue_addr,
  input  logic [DATA_WIDTH-1:0] issue_exp,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_exp,
  output logic [DATA_WIDTH-1:0] fail_act,
  output logic [CNT_WIDTH-1:0]  err_cnt
);

  logic                  pend;
  logic [ADDR_WIDTH-1:0] pend_addr;
  logic [DATA_WIDTH-1:0] pend_exp;
  logic                  mismatch;

  assign mismatch = pend && (rdata != pend_exp);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend      <= 1'b0;
      pend_addr <= '0;
      pend_exp  <= '0;
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_exp  <= '0;
      fail_act  <= '0;
      err_cnt   <= '0;
    end else begin
      pend      <= issue;
      pend_addr <= issue_addr;
      pend_exp  <= issue_exp;
      if (clear) begin
        fail      <= 1'b0;
        fail_addr <= '0;
        fail_exp  <= '0;
        fail_act  <= '0;
        err_cnt   <= '0;
      end else if (mismatch) begin
        fail <= 1'b1;
        if (err_cnt != {CNT_WIDTH{1'b1}}) begin
          err_cnt <= err_cnt + CNT_WIDTH'(1);
        end
        // Only the first mismatch of a run is recorded.
        if (!fail) begin
          fail_addr <= pend_addr;
          fail_exp  <= pend_exp;
          fail_act  <= rdata;
        end
      end
    end
  end

endmodule

// File: rtl/ram_bist_ctrl.sv
// March C- BIST initiator: sequences elements M0..M5 over every RAM address,
// drives the RAM ports combinationally from state + address, and feeds bist_cmp.
module ram_bist_ctrl
  import ram_bist_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  bg,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_exp,
  output logic [DATA_WIDTH-1:0] fail_act,
  output logic [CNT_WIDTH-1:0]  err_cnt
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr, addr_nxt;
  logic                  bg_q, bg_nxt;
  logic                  start_acc;
  logic                  last_addr;
  march_elem_t           elem;
  logic [DATA_WIDTH-1:0] exp_word;

  assign elem      = elem_of(state);
  assign last_addr = elem.dir_down ? (addr == '0) : (addr == ADDR_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      addr  <= '0;
      bg_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      addr  <= addr_nxt;
      bg_q  <= bg_nxt;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    bg_nxt    = bg_q;
    start_acc = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          start_acc = 1'b1;
          state_nxt = ST_M0;
          addr_nxt  = '0;
          bg_nxt    = bg;
        end
      end
      ST_M0, ST_M1, ST_M2, ST_M3, ST_M4, ST_M5: begin
        if (last_addr) begin
          state_nxt = next_elem(state);
          addr_nxt  = elem_of(next_elem(state)).dir_down ? ADDR_LAST : '0;
        end else if (elem.dir_down) begin
          addr_nxt = addr - ADDR_WIDTH'(1);
        end else begin
          addr_nxt = addr + ADDR_WIDTH'(1);
        end
      end
      ST_DRAIN: state_nxt = ST_DONE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Read and write share the address; the RAM returns the pre-write word.
  assign mem_we    = elem.do_write;
  assign mem_re    = elem.do_read;
  assign mem_waddr = addr;
  assign mem_raddr = addr;
  assign mem_wdata = {DATA_WIDTH{elem.write_val ^ bg_q}};
  assign exp_word  = {DATA_WIDTH{elem.read_val ^ bg_q}};

  assign busy = (state != ST_IDLE) && (state != ST_DONE);
  assign done = (state == ST_DONE);

  bist_cmp #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_cmp (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_acc),
    .issue      (mem_re),
    .issue_addr (addr),
    .issue_exp  (exp_word),
    .rdata      (mem_rdata),
    .fail       (fail),
    .fail_addr  (fail_addr),
    .fail_exp   (fail_exp),
    .fail_act   (fail_act),
    .err_cnt    (err_cnt)
  );

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl against a behavioural sync RAM with injectable stuck-at-0 bits;
// a second instance with a 1-bit counter shares the same read data to observe saturation.
module tb_ram_bist_ctrl;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int N  = 16;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          bg = 1'b0;
  logic          mem_we, mem_re;
  logic [AW-1:0] mem_waddr, mem_raddr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          busy, done, fail;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_exp, fail_act;
  logic [CW-1:0] err_cnt;

  logic          s_we, s_re, s_busy, s_done, s_fail;
  logic [AW-1:0] s_waddr, s_raddr, s_fail_addr;
  logic [DW-1:0] s_wdata, s_fail_exp, s_fail_act;
  logic [0:0]    s_err_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ram_bist_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .bg(bg),
    .mem_we(mem_we), .mem_re(mem_re), .mem_waddr(mem_waddr), .mem_raddr(mem_raddr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .fail(fail), .fail_addr(fail_addr),
    .fail_exp(fail_exp), .fail_act(fail_act), .err_cnt(err_cnt)
  );

  ram_bist_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(1)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .bg(bg),
    .mem_we(s_we), .mem_re(s_re), .mem_waddr(s_waddr), .mem_raddr(s_raddr),
    .mem_wdata(s_wdata), .mem_rdata(mem_rdata),
    .busy(s_busy), .done(s_done), .fail(s_fail), .fail_addr(s_fail_addr),
    .fail_exp(s_fail_exp), .fail_act(s_fail_act), .err_cnt(s_err_cnt)
  );

  // Behavioural RAM: registered read of the pre-write word, stuck-at-0 mask on the output.
  logic [DW-1:0] ram [N];
  logic [DW-1:0] ram_q;
  logic [AW-1:0] ram_raddr_q;
  logic [DW-1:0] stuck0 [N];

  always @(posedge clk) begin
    if (mem_we) ram[mem_waddr] <= mem_wdata;
    if (mem_re) begin
      ram_q       <= ram[mem_raddr];
      ram_raddr_q <= mem_raddr;
    end
  end

  assign mem_rdata = ram_q & ~stuck0[ram_raddr_q];

  typedef struct packed {
    logic          we;
    logic          re;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } acc_t;

  acc_t exp_q[$];
  int            exp_err;
  logic          exp_fail;
  logic [AW-1:0] exp_faddr;
  logic [DW-1:0] exp_fexp, exp_fact;

  // Independent March C- description: direction, read?, read value, write?, write value.
  bit el_down [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  bit el_rd   [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  bit el_rv   [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  bit el_wr   [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  bit el_wv   [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

  task automatic clear_faults();
    for (int i = 0; i < N; i++) stuck0[i] = '0;
  endtask

  task automatic build_expected(input logic b);
    acc_t          acc;
    int            a;
    logic          rbit, wbit;
    logic [DW-1:0] v, act;
    exp_q.delete();
    exp_err   = 0;
    exp_fail  = 1'b0;
    exp_faddr = '0;
    exp_fexp  = '0;
    exp_fact  = '0;
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < N; i++) begin
        a         = el_down[e] ? (N - 1 - i) : i;
        wbit      = el_wv[e] ^ b;
        rbit      = el_rv[e] ^ b;
        acc.we    = el_wr[e];
        acc.re    = el_rd[e];
        acc.addr  = AW'(a);
        acc.wdata = {DW{wbit}};
        exp_q.push_back(acc);
        if (el_rd[e]) begin
          v   = {DW{rbit}};
          act = v & ~stuck0[a];
          if (act != v) begin
            exp_err++;
            if (!exp_fail) begin
              exp_fail  = 1'b1;
              exp_faddr = AW'(a);
              exp_fexp  = v;
              exp_fact  = act;
            end
          end
        end
      end
    end
    acc = '0;
    exp_q.push_back(acc);
  endtask

  // Starts a run and scores RAM traffic every cycle through to done; a start
  // pulse is injected mid-run when pulse_at >= 0.
  task automatic run_and_score(input logic b, input int pulse_at);
    acc_t acc;
    bg = b;
    build_expected(b);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int j = 0; j <= 6 * N; j++) begin
      acc = exp_q.pop_front();
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || mem_we !== acc.we || mem_re !== acc.re ||
          (acc.re && mem_raddr !== acc.addr) ||
          (acc.we && (mem_waddr !== acc.addr || mem_wdata !== acc.wdata))) begin
        errors++;
        $display("FAIL traffic cycle %0d: got busy=%b done=%b we=%b re=%b wa=%h ra=%h wd=%h, want busy=1 done=0 we=%b re=%b addr=%h wd=%h",
                 j, busy, done, mem_we, mem_re, mem_waddr, mem_raddr, mem_wdata,
                 acc.we, acc.re, acc.addr, acc.wdata);
      end
      if (j == 0) begin
        checks++;
        if (fail !== 1'b0 || err_cnt !== '0 || fail_addr !== '0) begin
          errors++;
          $display("FAIL start_clear: got fail=%b err_cnt=%0d fail_addr=%h, want 0/0/0",
                   fail, err_cnt, fail_addr);
        end
      end
      if (j == pulse_at) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || mem_we !== 1'b0 || mem_re !== 1'b0) begin
      errors++;
      $display("FAIL done_timing: got done=%b busy=%b we=%b re=%b at edge %0d, want 1/0/0/0",
               done, busy, mem_we, mem_re, 6 * N + 1);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", exp_q.size());
    end
  endtask

  task automatic check_results(input string name);
    checks++;
    if (fail !== exp_fail || err_cnt !== CW'(exp_err) ||
        (exp_fail && (fail_addr !== exp_faddr || fail_exp !== exp_fexp || fail_act !== exp_fact))) begin
      errors++;
      $display("FAIL %s results: got fail=%b cnt=%0d addr=%h exp=%h act=%h, want fail=%b cnt=%0d addr=%h exp=%h act=%h",
               name, fail, err_cnt, fail_addr, fail_exp, fail_act,
               exp_fail, exp_err, exp_faddr, exp_fexp, exp_fact);
    end
    checks++;
    if (s_err_cnt !== ((exp_err > 0) ? 1'b1 : 1'b0) || s_fail !== exp_fail) begin
      errors++;
      $display("FAIL %s sat_counter: got cnt=%b fail=%b, want cnt=%b fail=%b",
               name, s_err_cnt, s_fail, (exp_err > 0), exp_fail);
    end
  endtask

  task automatic test_reset();
    clear_faults();
    rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || fail !== 1'b0 || mem_we !== 1'b0 || mem_re !== 1'b0 ||
        mem_waddr !== '0 || mem_wdata !== '0 || err_cnt !== '0 || fail_addr !== '0 ||
        fail_exp !== '0 || fail_act !== '0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b fail=%b we=%b re=%b cnt=%0d, want all 0",
               busy, done, fail, mem_we, mem_re, err_cnt);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: got busy=%b done=%b, want 0/0", busy, done);
    end
  endtask

  task automatic test_good_bg0();
    clear_faults();
    run_and_score(1'b0, 20);
    check_results("good_bg0");
  endtask

  task automatic test_good_bg1();
    clear_faults();
    run_and_score(1'b1, -1);
    check_results("good_bg1");
  endtask

  task automatic test_stuck_at();
    clear_faults();
    stuck0[5] = 8'h08;
    run_and_score(1'b0, -1);
    check_results("stuck_addr5");
    checks++;
    if (fail_addr !== 4'd5 || fail_exp !== 8'hFF || fail_act !== 8'hF7 || err_cnt !== CW'(2)) begin
      errors++;
      $display("FAIL stuck_addr5 literal: got addr=%h exp=%h act=%h cnt=%0d, want 5/ff/f7/2",
               fail_addr, fail_exp, fail_act, err_cnt);
    end
  endtask

  task automatic test_two_faults();
    clear_faults();
    stuck0[2] = 8'h08;
    stuck0[9] = 8'h08;
    run_and_score(1'b0, -1);
    check_results("two_faults");
    checks++;
    if (fail_addr !== 4'd2 || err_cnt !== CW'(4) || s_err_cnt !== 1'b1) begin
      errors++;
      $display("FAIL two_faults literal: got addr=%h cnt=%0d sat_cnt=%b, want 2/4/1",
               fail_addr, err_cnt, s_err_cnt);
    end
  endtask

  task automatic test_restart_from_done();
    clear_faults();
    run_and_score(1'b0, -1);
    check_results("restart_from_done");
  endtask

  task automatic test_reset_abort();
    clear_faults();
    stuck0[5] = 8'h08;
    bg = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (fail !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_precondition: got fail=%b busy=%b, want 1/1", fail, busy);
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || fail !== 1'b0 || mem_we !== 1'b0 || mem_re !== 1'b0 ||
        err_cnt !== '0) begin
      errors++;
      $display("FAIL reset_abort: got busy=%b done=%b fail=%b we=%b re=%b cnt=%0d, want all 0",
               busy, done, fail, mem_we, mem_re, err_cnt);
    end
    @(negedge clk);
    rst = 1'b1;
    clear_faults();
    run_and_score(1'b0, -1);
    check_results("after_abort");
  endtask

  initial begin
    clear_faults();
    test_reset();
    test_good_bg0();
    test_good_bg1();
    test_stuck_at();
    test_two_faults();
    test_restart_from_done();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
